// File: rtl/dm_rom_arbiter.sv
// rtl/dm_rom_arbiter.sv - two-port round-robin arbiter in front of a 64-bit debug ROM
//
// Purpose: grants one of two 32-bit word requesters per cycle, forwards in-range
// reads to a 64-bit wide ROM and returns the selected 32-bit lane one cycle later.
// Out-of-range accesses never touch the ROM and return err=1, rdata=0.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   pN_req_i, pN_addr_i            port request and byte address (held until granted)
//   pN_gnt_o                       combinational grant, transaction completes that cycle
//   pN_rvalid_o, pN_rdata_o,       registered response, one cycle after the grant
//   pN_err_o
//   rom_req_o, rom_addr_o          ROM read request, 8-byte aligned address
//   rom_rdata_i                    ROM read data, valid the cycle after rom_req_o
module dm_rom_arbiter #(
    parameter logic [31:0] ROM_BASE  = 32'h0000_0800,
    parameter logic [31:0] ROM_BYTES = 32'h0000_0800
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_req_i,
    input  logic [31:0] p0_addr_i,
    output logic        p0_gnt_o,
    output logic        p0_rvalid_o,
    output logic [31:0] p0_rdata_o,
    output logic        p0_err_o,
    input  logic        p1_req_i,
    input  logic [31:0] p1_addr_i,
    output logic        p1_gnt_o,
    output logic        p1_rvalid_o,
    output logic [31:0] p1_rdata_o,
    output logic        p1_err_o,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic [63:0] rom_rdata_i
);

    // Window bounds in 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, ROM_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, ROM_BASE} + {1'b0, ROM_BYTES} - 33'd1;

    logic last_gnt_q, last_gnt_d;
    logic resp_valid_q, resp_valid_d;
    logic resp_port_q, resp_port_d;
    logic resp_lane_q, resp_lane_d;
    logic resp_err_q, resp_err_d;

    logic        gnt_any;
    logic        gnt_port;
    logic [31:0] sel_addr;
    logic        in_range;
    logic        rsp_on;
    logic [31:0] rsp_data;

    // Request side: grant, ROM request and next response-pipeline state.
    always_comb begin
        gnt_any      = 1'b0;
        gnt_port     = 1'b0;
        sel_addr     = 32'h0;
        in_range     = 1'b0;
        p0_gnt_o     = 1'b0;
        p1_gnt_o     = 1'b0;
        rom_req_o    = 1'b0;
        rom_addr_o   = 32'h0;
        last_gnt_d   = last_gnt_q;
        resp_valid_d = 1'b0;
        resp_port_d  = 1'b0;
        resp_lane_d  = 1'b0;
        resp_err_d   = 1'b0;

        // No grants while reset is held, so a request in a reset cycle stays pending.
        gnt_any  = !rst_i && (p0_req_i || p1_req_i);
        // On a tie the port that did not win last time goes; otherwise the lone requester.
        gnt_port = (p0_req_i && p1_req_i) ? ~last_gnt_q : p1_req_i;
        sel_addr = gnt_port ? p1_addr_i : p0_addr_i;
        in_range = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} <= WIN_HI);

        if (gnt_any) begin
            p0_gnt_o     = !gnt_port;
            p1_gnt_o     = gnt_port;
            last_gnt_d   = gnt_port;
            resp_valid_d = 1'b1;
            resp_port_d  = gnt_port;
            resp_lane_d  = sel_addr[2];
            resp_err_d   = !in_range;
            if (in_range) begin
                rom_req_o  = 1'b1;
                rom_addr_o = {sel_addr[31:3], 3'b000};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_q   <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_lane_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            resp_valid_q <= resp_valid_d;
            resp_port_q  <= resp_port_d;
            resp_lane_q  <= resp_lane_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Response side: route the selected lane to the port that owns the response.
    always_comb begin
        rsp_on      = resp_valid_q && !rst_i;
        rsp_data    = 32'h0;
        p0_rvalid_o = 1'b0;
        p1_rvalid_o = 1'b0;
        p0_rdata_o  = 32'h0;
        p1_rdata_o  = 32'h0;
        p0_err_o    = 1'b0;
        p1_err_o    = 1'b0;

        if (!resp_err_q) begin
            rsp_data = resp_lane_q ? rom_rdata_i[63:32] : rom_rdata_i[31:0];
        end

        if (rsp_on) begin
            if (resp_port_q) begin
                p1_rvalid_o = 1'b1;
                p1_rdata_o  = rsp_data;
                p1_err_o    = resp_err_q;
            end else begin
                p0_rvalid_o = 1'b1;
                p0_rdata_o  = rsp_data;
                p0_err_o    = resp_err_q;
            end
        end
    end

endmodule

// File: tb/tb_dm_rom_arbiter.sv
// tb/tb_dm_rom_arbiter.sv - scoreboard bench for dm_rom_arbiter
module tb_dm_rom_arbiter;

    localparam logic [31:0] BASE  = 32'h0000_0800;
    localparam logic [31:0] BYTES = 32'h0000_0800;

    logic        clk;
    logic        rst_i;
    logic        p0_req_i, p1_req_i;
    logic [31:0] p0_addr_i, p1_addr_i;
    logic        p0_gnt_o, p1_gnt_o;
    logic        p0_rvalid_o, p1_rvalid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        p0_err_o, p1_err_o;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic [63:0] rom_rdata_i;

    dm_rom_arbiter #(.ROM_BASE(BASE), .ROM_BYTES(BYTES)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_gnt_o(p0_gnt_o),
        .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o), .p0_err_o(p0_err_o),
        .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_gnt_o(p1_gnt_o),
        .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o), .p1_err_o(p1_err_o),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 0;
    int model_last = 1;

    typedef struct {
        int          stamp;
        bit          port;
        bit          err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rom_mem(input logic [31:0] a);
        if (a == 32'h0000_0800) return 64'hAAAA_BBBB_CCCC_DDDD;
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    // ROM model: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (rom_req_o) rom_rdata_i <= rom_mem(rom_addr_o);
        else           rom_rdata_i <= {$urandom, $urandom};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; checks the combinational request side and queues the response.
    task automatic step(input bit r, input bit q0, input logic [31:0] a0,
                        input bit q1, input logic [31:0] a1, output int gp);
        logic [31:0] a;
        logic [63:0] w;
        bit ok;
        exp_t e;
        @(posedge clk);
        #1;
        rst_i = r; p0_req_i = q0; p0_addr_i = a0; p1_req_i = q1; p1_addr_i = a1;
        @(negedge clk);
        gp = -1;
        if (!r) begin
            if (q0 && q1)  gp = 1 - model_last;
            else if (q0)   gp = 0;
            else if (q1)   gp = 1;
        end
        a  = (gp == 1) ? a1 : a0;
        ok = (gp >= 0) && (longint'(a) >= longint'(BASE)) &&
             (longint'(a) < longint'(BASE) + longint'(BYTES));
        chk("p0_gnt", p0_gnt_o, gp == 0);
        chk("p1_gnt", p1_gnt_o, gp == 1);
        chk("rom_req", rom_req_o, ok);
        chk("rom_addr", rom_addr_o, ok ? (a & 32'hFFFF_FFF8) : 32'h0);
        if (r) model_last = 1;
        else if (gp >= 0) model_last = gp;
        if (gp >= 0) begin
            w = rom_mem(a & 32'hFFFF_FFF8);
            e.stamp = cyc;
            e.port  = (gp == 1);
            e.err   = !ok;
            e.data  = !ok ? 32'h0 : (a[2] ? w[63:32] : w[31:0]);
            sb.push_back(e);
        end
    endtask

    // Monitor: compares both ports' response outputs against the queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            bit have;
            exp_t e;
            while (sb.size() > 0 && sb[0].stamp < cyc - 1) begin
                errors++;
                checks++;
                $display("FAIL stale_resp: got none expected port %0d stamp %0d", sb[0].port, sb[0].stamp);
                void'(sb.pop_front());
            end
            have = (sb.size() > 0) && (sb[0].stamp == cyc - 1);
            if (have) e = sb.pop_front();
            if (rst_i) have = 0;
            chk("p0_rvalid", p0_rvalid_o, have && !e.port);
            chk("p1_rvalid", p1_rvalid_o, have && e.port);
            chk("p0_rdata", p0_rdata_o, (have && !e.port) ? e.data : 32'h0);
            chk("p1_rdata", p1_rdata_o, (have && e.port) ? e.data : 32'h0);
            chk("p0_err", p0_err_o, have && !e.port && e.err);
            chk("p1_err", p1_err_o, have && e.port && e.err);
        end
    end

    initial begin
        int g;
        bit pend0, pend1, r;
        logic [31:0] pa0, pa1;
        logic [31:0] pick [8];

        rst_i = 1; p0_req_i = 0; p1_req_i = 0; p0_addr_i = 0; p1_addr_i = 0;
        step(1, 0, 0, 0, 0, g);
        mon_en = 1;
        step(1, 1, 32'h800, 1, 32'h804, g);

        // Single read lane 0
        step(0, 1, 32'h800, 0, 0, g);
        step(0, 0, 0, 0, 0, g);
        chk("lane0_data", p0_rdata_o, 32'hCCCC_DDDD);

        // Single read lane 1
        step(0, 0, 0, 1, 32'h80C, g);
        chk("lane1_addr_ok", g, 1);
        step(0, 0, 0, 0, 0, g);
        chk("lane1_data", p1_rdata_o, rom_mem(32'h808) >> 32);

        // Continuous contention after reset
        step(1, 0, 0, 0, 0, g);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'h800 + 32'(i * 8), 1, 32'h804 + 32'(i * 8), g);
            chk("alt_grant", g, i % 2);
        end

        // Range boundaries
        step(0, 1, 32'h1000, 0, 0, g);
        step(0, 0, 0, 1, 32'h7FC, g);
        step(0, 1, 32'hFFC, 0, 0, g);
        step(0, 0, 0, 1, 32'hFFFF_FFFC, g);
        step(0, 1, 32'h803, 0, 0, g);

        // Reset during grant cycle, then tie goes to p0
        step(0, 0, 0, 1, 32'h900, g);
        step(1, 1, 32'h800, 0, 0, g);
        step(0, 1, 32'h800, 1, 32'h804, g);
        chk("post_reset_tie", g, 0);

        // Back-to-back single port
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h800 + 32'(i * 4), 0, 0, g);
            chk("b2b_grant", g, 0);
        end

        // Randomized traffic with held requests and occasional resets
        pick[0] = 32'h7FC; pick[1] = 32'h800; pick[2] = 32'hFFC; pick[3] = 32'h1000;
        pick[4] = 32'hFFFF_FFFC; pick[5] = 32'h0; pick[6] = 32'h800; pick[7] = 32'h900;
        pend0 = 0; pend1 = 0; pa0 = 0; pa1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend0 && ($urandom % 3 != 0)) begin
                pend0 = 1;
                pa0 = ($urandom % 2) ? pick[$urandom % 8] : 32'h780 + ($urandom % 32'h900);
            end
            if (!pend1 && ($urandom % 3 != 0)) begin
                pend1 = 1;
                pa1 = ($urandom % 2) ? pick[$urandom % 8] : 32'h780 + ($urandom % 32'h900);
            end
            r = ($urandom % 40 == 0);
            step(r, pend0, pa0, pend1, pa1, g);
            if (g == 0) pend0 = 0;
            if (g == 1) pend1 = 0;
        end

        step(0, 0, 0, 0, 0, g);
        step(0, 0, 0, 0, 0, g);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
